mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous generic_mem instance between the instruction-fetch (I) and

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch (I)
// and load/store (D) requesters. Each cycle at most one request is granted:
// its byte address is checked, the memory port is driven, and one cycle later
// a response (read data or error) is presented to the requester that owned
// the slot. Sustains one access per cycle in total, pipeline depth 1.
//
// Ports
//   clock, reset_n           clock and asynchronous active-low reset
//   i_req_valid/ready/addr   fetch request (read only); ready is the grant
//   i_rsp_valid/data/err     fetch response, 1-cycle pulse, no back-pressure
//   d_req_valid/ready/addr   LSU request; d_req_we selects write, with
//   d_req_we/wdata             d_req_wdata as the write data
//   d_rsp_valid/data/err     LSU response for reads and writes (data 0 for
//                              writes and errors)
//   mem_write_en/address     memory port: word index, write enable, write data
//   mem_data_i/mem_data_o      and registered read data (valid next cycle)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int WORDSIZE = 4,
   parameter int MEMSIZE  = 32*1024,
   parameter int ARB_MODE = 0,
   localparam int W  = WORDSIZE*8,
   localparam int AW = $clog2(MEMSIZE)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          i_req_valid,
   output logic          i_req_ready,
   input  logic [31:0]   i_req_addr,
   output logic          i_rsp_valid,
   output logic [W-1:0]  i_rsp_data,
   output logic          i_rsp_err,
   input  logic          d_req_valid,
   output logic          d_req_ready,
   input  logic [31:0]   d_req_addr,
   input  logic          d_req_we,
   input  logic [W-1:0]  d_req_wdata,
   output logic          d_rsp_valid,
   output logic [W-1:0]  d_rsp_data,
   output logic          d_rsp_err,
   output logic          mem_write_en,
   output logic [AW-1:0] mem_address,
   output logic [W-1:0]  mem_data_i,
   input  logic [W-1:0]  mem_data_o
);

   localparam int          OB        = $clog2(WORDSIZE);
   localparam logic [31:0] OFS_MASK  = 32'(WORDSIZE - 1);
   localparam logic [31:0] MEM_WORDS = 32'(MEMSIZE);

   typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} port_e;

   port_e       last_q, last_d;
   logic [31:0] i_idx, d_idx;
   logic        i_err, d_err;
   logic        gnt_i, gnt_d;

   logic        i_vld_q, i_vld_d, i_err_q, i_err_d, i_rd_q, i_rd_d;
   logic        d_vld_q, d_vld_d, d_err_q, d_err_d, d_rd_q, d_rd_d;

   // Address check: misaligned byte offset or word index beyond the memory.
   always_comb begin
      i_idx = i_req_addr >> OB;
      d_idx = d_req_addr >> OB;
      i_err = ((i_req_addr & OFS_MASK) != '0) || (i_idx >= MEM_WORDS);
      d_err = ((d_req_addr & OFS_MASK) != '0) || (d_idx >= MEM_WORDS);
   end

   // Grant is combinational and forced off while reset is held. On contention
   // round-robin hands the slot to the port that did not win last time.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (reset_n) begin
         if (i_req_valid && d_req_valid) begin
            if (ARB_MODE == 1 || last_q == GNT_I) gnt_d = 1'b1;
            else                                  gnt_i = 1'b1;
         end else begin
            gnt_i = i_req_valid;
            gnt_d = d_req_valid;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt_d)      last_d = GNT_D;
      else if (gnt_i) last_d = GNT_I;
   end

   assign i_req_ready = gnt_i;
   assign d_req_ready = gnt_d;

   // Errored grants still consume the slot but never touch the memory.
   always_comb begin
      mem_write_en = gnt_d && d_req_we && !d_err;
      mem_address  = '0;
      mem_data_i   = '0;
      if (gnt_i && !i_err) begin
         mem_address = i_idx[AW-1:0];
      end else if (gnt_d && !d_err) begin
         mem_address = d_idx[AW-1:0];
         mem_data_i  = d_req_wdata;
      end
   end

   // The *_rd flags mark a successful read whose data arrives from memory
   // next cycle; everything else returns zero data.
   always_comb begin
      i_vld_d = gnt_i;
      i_err_d = gnt_i && i_err;
      i_rd_d  = gnt_i && !i_err;
      d_vld_d = gnt_d;
      d_err_d = gnt_d && d_err;
      d_rd_d  = gnt_d && !d_err && !d_req_we;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q  <= GNT_D;
         i_vld_q <= 1'b0;
         i_err_q <= 1'b0;
         i_rd_q  <= 1'b0;
         d_vld_q <= 1'b0;
         d_err_q <= 1'b0;
         d_rd_q  <= 1'b0;
      end else begin
         last_q  <= last_d;
         i_vld_q <= i_vld_d;
         i_err_q <= i_err_d;
         i_rd_q  <= i_rd_d;
         d_vld_q <= d_vld_d;
         d_err_q <= d_err_d;
         d_rd_q  <= d_rd_d;
      end
   end

   // Response stage: the memory's registered read data is steered to the
   // port that issued the read.
   assign i_rsp_valid = i_vld_q;
   assign i_rsp_err   = i_err_q;
   assign i_rsp_data  = i_rd_q ? mem_data_o : '0;
   assign d_rsp_valid = d_vld_q;
   assign d_rsp_err   = d_err_q;
   assign d_rsp_data  = d_rd_q ? mem_data_o : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int NW = 32768;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req_valid = 1'b0, d_req_valid = 1'b0, d_req_we = 1'b0;
   logic [31:0] i_req_addr = '0, d_req_addr = '0, d_req_wdata = '0;

   logic        i_req_ready [2], d_req_ready [2];
   logic        i_rsp_valid [2], i_rsp_err [2], d_rsp_valid [2], d_rsp_err [2];
   logic        mem_write_en [2];
   logic [31:0] i_rsp_data [2], d_rsp_data [2], mem_data_i [2], mem_data_o [2];
   logic [14:0] mem_address [2];

   logic [31:0] gmem0 [NW];
   logic [31:0] gmem1 [NW];

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // Reference model state: one memory image and last winner per DUT mode.
   logic [31:0] refmem [2][64];
   bit          last_is_d [2];
   exp_t        sbq [4][$];   // index = mode*2 + port (0 = I, 1 = D)

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mem_port_arbiter #(.WORDSIZE(4), .MEMSIZE(NW), .ARB_MODE(0)) u_rr (
      .clock(clock), .reset_n(reset_n),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready[0]), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid[0]), .i_rsp_data(i_rsp_data[0]), .i_rsp_err(i_rsp_err[0]),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready[0]), .d_req_addr(d_req_addr),
      .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid[0]), .d_rsp_data(d_rsp_data[0]), .d_rsp_err(d_rsp_err[0]),
      .mem_write_en(mem_write_en[0]), .mem_address(mem_address[0]),
      .mem_data_i(mem_data_i[0]), .mem_data_o(mem_data_o[0]));

   mem_port_arbiter #(.WORDSIZE(4), .MEMSIZE(NW), .ARB_MODE(1)) u_fp (
      .clock(clock), .reset_n(reset_n),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready[1]), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid[1]), .i_rsp_data(i_rsp_data[1]), .i_rsp_err(i_rsp_err[1]),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready[1]), .d_req_addr(d_req_addr),
      .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid[1]), .d_rsp_data(d_rsp_data[1]), .d_rsp_err(d_rsp_err[1]),
      .mem_write_en(mem_write_en[1]), .mem_address(mem_address[1]),
      .mem_data_i(mem_data_i[1]), .mem_data_o(mem_data_o[1]));

   // Behavioural single-port synchronous memories, one per DUT.
   initial begin
      for (int i = 0; i < NW; i++) begin
         gmem0[i] = '0;
         gmem1[i] = '0;
      end
      forever begin
         @(posedge clock);
         if (mem_write_en[0]) gmem0[mem_address[0]] <= mem_data_i[0];
         if (mem_write_en[1]) gmem1[mem_address[1]] <= mem_data_i[1];
         mem_data_o[0] <= gmem0[mem_address[0]];
         mem_data_o[1] <= gmem1[mem_address[1]];
      end
   end

   task automatic chk(input string name, input int m, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s (mode %0d) at cycle %0d: got %h, expected %h", name, m, cyc, got, want);
      end
   endtask

   function automatic bit addr_err(input logic [31:0] a);
      return (a % 4 != 0) || ((a / 4) >= NW);
   endfunction

   // Drives one request cycle, checks the combinational grant and memory
   // controls, then lets the model perform the access and queue the response.
   task automatic cycle(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                        input logic [31:0] da, input logic [31:0] dd, input bit rel);
      @(negedge clock);
      if (rel) reset_n = 1'b1;
      i_req_valid = iv; i_req_addr = ia;
      d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dd;
      #1;
      for (int m = 0; m < 2; m++) begin
         int          who;   // 0 none, 1 I, 2 D
         bit          e;
         logic [31:0] a, exp_data;
         who = 0;
         if (reset_n) begin
            if (iv && dv)  who = (m == 1) ? 2 : (last_is_d[m] ? 1 : 2);
            else if (iv)   who = 1;
            else if (dv)   who = 2;
         end
         chk("i_req_ready", m, 32'(i_req_ready[m]), 32'(who == 1));
         chk("d_req_ready", m, 32'(d_req_ready[m]), 32'(who == 2));
         a = (who == 1) ? ia : da;
         e = addr_err(a);
         chk("mem_write_en", m, 32'(mem_write_en[m]), 32'(who == 2 && dwe && !e));
         if (who != 0) begin
            if (!e) chk("mem_address", m, 32'(mem_address[m]), a / 4);
            last_is_d[m] = (who == 2);
            exp_data = '0;
            if (!e && (a / 4) < 64) begin
               if (who == 2 && dwe) refmem[m][a / 4] = dd;
               else                 exp_data = refmem[m][a / 4];
            end
            sbq[m*2 + who - 1].push_back('{due: cyc + 1, data: exp_data, err: e});
         end
      end
   endtask

   task automatic pulse_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      for (int k = 0; k < 4; k++) sbq[k].delete();
      last_is_d[0] = 1'b1;
      last_is_d[1] = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(15);
      if (r == 0) return 32'($urandom_range(63)) * 4 + 32'($urandom_range(3, 1));
      if (r == 1) return ($urandom_range(1) == 1) ? 32'hFFFF_FFFC : 32'h0002_0000 + 32'($urandom_range(63)) * 4;
      return 32'($urandom_range(63)) * 4;
   endfunction

   // Monitor: compares every presented response with the queued expectation,
   // and requires quiet response outputs when nothing is due.
   initial begin
      forever begin
         @(posedge clock);
         #2;
         for (int k = 0; k < 4; k++) begin
            int          m;
            logic        v, e;
            logic [31:0] d;
            m = k / 2;
            v = (k % 2 == 0) ? i_rsp_valid[m] : d_rsp_valid[m];
            e = (k % 2 == 0) ? i_rsp_err[m]   : d_rsp_err[m];
            d = (k % 2 == 0) ? i_rsp_data[m]  : d_rsp_data[m];
            if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
               exp_t x;
               x = sbq[k].pop_front();
               chk((k % 2 == 0) ? "i_rsp_valid" : "d_rsp_valid", m, 32'(v), 32'd1);
               chk((k % 2 == 0) ? "i_rsp_data" : "d_rsp_data", m, d, x.data);
               chk((k % 2 == 0) ? "i_rsp_err" : "d_rsp_err", m, 32'(e), 32'(x.err));
            end else begin
               chk((k % 2 == 0) ? "i_rsp_idle" : "d_rsp_idle", m, {d[29:0], v, e}, 32'd0);
            end
         end
      end
   end

   initial begin
      for (int m = 0; m < 2; m++) begin
         last_is_d[m] = 1'b1;
         for (int w = 0; w < 64; w++) refmem[m][w] = '0;
      end

      // Reset held with both requesters active, then release: I wins first
      // contention under round-robin, D under fixed priority.
      cycle(1, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0);
      cycle(1, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0);
      cycle(1, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 1);
      cycle(0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0);
      // Fetch read of the preloaded word.
      cycle(1, 32'h10, 0, 0, 32'h0, 32'h0, 0);
      // Write then read of the same word in consecutive cycles.
      cycle(0, 32'h0, 1, 1, 32'h20, 32'h1234_5678, 0);
      cycle(0, 32'h0, 1, 0, 32'h20, 32'h0, 0);
      // Sustained contention.
      for (int n = 0; n < 4; n++) cycle(1, 32'h10, 1, 0, 32'h20, 32'h0, 0);
      // Misaligned write, out-of-range fetch, then confirm memory unchanged.
      cycle(0, 32'h0, 1, 1, 32'h22, 32'hBAD0_BAD0, 0);
      cycle(1, 32'h0002_0000, 0, 0, 32'h0, 32'h0, 0);
      cycle(0, 32'h0, 1, 0, 32'h20, 32'h0, 0);
      // Reset right after a read grant drops the pending response.
      cycle(0, 32'h0, 1, 0, 32'h10, 32'h0, 0);
      pulse_reset();
      cycle(1, 32'h4, 1, 1, 32'h8, 32'h5555_AAAA, 0);
      cycle(1, 32'h4, 1, 1, 32'h8, 32'h5555_AAAA, 1);
      cycle(1, 32'h8, 1, 0, 32'h4, 32'h0, 0);

      // Randomized traffic with one mid-stream reset.
      for (int n = 0; n < 400; n++) begin
         if (n == 200) begin
            pulse_reset();
            cycle(1, rand_addr(), 1, 1, rand_addr(), $urandom, 0);
            cycle(1, rand_addr(), 1, $urandom_range(1) == 1, rand_addr(), $urandom, 1);
         end else begin
            cycle($urandom_range(3) != 0, rand_addr(), $urandom_range(3) != 0,
                  $urandom_range(1) == 1, rand_addr(), $urandom, 0);
         end
      end

      cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      repeat (3) @(posedge clock);
      #3;
      for (int k = 0; k < 4; k++) chk("drain", k / 2, 32'(sbq[k].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
